// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage 2-bit saturating-counter branch predictor.
// Counter encodings, the counter reset value and the default table/history sizes.
package branch_predictor_pkg;

  localparam int BP_IDX_BITS_DEF  = 6;
  localparam int BP_HIST_BITS_DEF = 6;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_cnt_e;

  localparam logic [1:0] BP_CNT_RST = BP_WNT;

endpackage

// File: rtl/bp_sat_counter2.sv
// Next-state logic for one 2-bit saturating counter (used once, on the BHT update path).
module bp_sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_taken,
  output logic [1:0] o_cnt_next
);

  always_comb begin
    o_cnt_next = i_cnt;
    if (i_taken) begin
      if (i_cnt != BP_ST) o_cnt_next = i_cnt + 2'd1;
    end else begin
      if (i_cnt != BP_SNT) o_cnt_next = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage BHT of 2-bit counters, trained from EX, with resolved/mispredict counters.
// Optional gshare indexing with a non-speculative global history: define BP_GSHARE_EN.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS  = BP_IDX_BITS_DEF,
  parameter int HIST_BITS = BP_HIST_BITS_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [31:0]         i_lkp_pc,
  output logic                o_pred_taken,
  output logic [IDX_BITS-1:0] o_pred_idx,
  input  logic                i_upd_valid,
  input  logic [IDX_BITS-1:0] i_upd_idx,
  input  logic                i_upd_taken,
  input  logic                i_upd_pred,
  output logic                o_mispredict,
  output logic [31:0]         o_stat_branches,
  output logic [31:0]         o_stat_mispred
);

  localparam int ENTRIES = 1 << IDX_BITS;

  // Flop array rather than RAM so the whole table resets in one cycle.
  logic [1:0]          r_bht [ENTRIES];
  logic                r_mispredict;
  logic [31:0]         r_stat_branches;
  logic [31:0]         r_stat_mispred;
  logic [IDX_BITS-1:0] w_lkp_base;
  logic [IDX_BITS-1:0] w_idx;
  logic [1:0]          w_upd_cnt;
  logic [1:0]          w_upd_cnt_next;
  logic                w_upd_miss;
  logic                w_unused_pc;

  assign w_lkp_base  = i_lkp_pc[IDX_BITS+1:2];
  assign w_unused_pc = ^{i_lkp_pc[31:IDX_BITS+2], i_lkp_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [HIST_BITS-1:0] r_ghr;

  assign w_idx = w_lkp_base ^ IDX_BITS'(r_ghr);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_ghr <= '0;
    else if (i_upd_valid) r_ghr <= HIST_BITS'({r_ghr, i_upd_taken});
  end
`else
  logic w_unused_hist;

  assign w_unused_hist = ^HIST_BITS;
  assign w_idx         = w_lkp_base;
`endif

  // Lookup reads the registered table: a same-cycle update to this index is not bypassed.
  assign o_pred_idx   = w_idx;
  assign o_pred_taken = r_bht[w_idx][1];

  assign w_upd_cnt  = r_bht[i_upd_idx];
  assign w_upd_miss = i_upd_taken != i_upd_pred;

  bp_sat_counter2 u_sat_counter (
    .i_cnt      (w_upd_cnt),
    .i_taken    (i_upd_taken),
    .o_cnt_next (w_upd_cnt_next)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= BP_CNT_RST;
      r_mispredict    <= 1'b0;
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else begin
      r_mispredict <= i_upd_valid && w_upd_miss;
      if (i_upd_valid) begin
        r_bht[i_upd_idx] <= w_upd_cnt_next;
        r_stat_branches  <= r_stat_branches + 32'd1;
        if (w_upd_miss) r_stat_mispred <= r_stat_mispred + 32'd1;
      end
    end
  end

  assign o_mispredict    = r_mispredict;
  assign o_stat_branches = r_stat_branches;
  assign o_stat_mispred  = r_stat_mispred;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor; gshare checks are used when BP_GSHARE_EN is defined.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lkp_pc;
  logic        pred_taken;
  logic [5:0]  pred_idx;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic        upd_pred;
  logic        mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(6), .HIST_BITS(6)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_lkp_pc        (lkp_pc),
    .o_pred_taken    (pred_taken),
    .o_pred_idx      (pred_idx),
    .i_upd_valid     (upd_valid),
    .i_upd_idx       (upd_idx),
    .i_upd_taken     (upd_taken),
    .i_upd_pred      (upd_pred),
    .o_mispredict    (mispredict),
    .o_stat_branches (stat_branches),
    .o_stat_mispred  (stat_mispred)
  );

  typedef struct {
    logic [31:0] pc;
    logic        uv;
    logic [5:0]  uidx;
    logic        ut;
    logic        up;
    logic        e_pred;
    logic [5:0]  e_idx;
    logic        e_misp;
    logic [31:0] e_br;
    logic [31:0] e_mp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic uv, input logic [5:0] uidx,
                       input logic ut, input logic up);
    lkp_pc    = pc;
    upd_valid = uv;
    upd_idx   = uidx;
    upd_taken = ut;
    upd_pred  = up;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(32'h0, 1'b0, 6'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifndef BP_GSHARE_EN
  vec_t vecs [$];

  task automatic add(input logic [31:0] pc, input logic uv, input logic [5:0] uidx,
                     input logic ut, input logic up, input logic e_pred, input logic [5:0] e_idx,
                     input logic e_misp, input logic [31:0] e_br, input logic [31:0] e_mp);
    vec_t v;
    v.pc = pc; v.uv = uv; v.uidx = uidx; v.ut = ut; v.up = up;
    v.e_pred = e_pred; v.e_idx = e_idx; v.e_misp = e_misp; v.e_br = e_br; v.e_mp = e_mp;
    vecs.push_back(v);
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    drive(32'h0, 1'b0, 6'h0, 1'b0, 1'b0);
    do_reset();

`ifndef BP_GSHARE_EN
    //   pc           uv  uidx  ut  up  pred idx  misp br  mp
    add(32'h100,     0, 6'h0, 0, 0,  0, 6'h00, 0,  0,  0);
    add(32'h100,     1, 6'h0, 1, 0,  0, 6'h00, 1,  1,  1);
    add(32'h100,     1, 6'h0, 1, 0,  1, 6'h00, 1,  2,  2);
    add(32'h100,     1, 6'h0, 1, 0,  1, 6'h00, 1,  3,  3);
    add(32'h100,     1, 6'h0, 1, 1,  1, 6'h00, 0,  4,  3);
    add(32'h100,     1, 6'h0, 0, 1,  1, 6'h00, 1,  5,  4);
    add(32'h100,     1, 6'h0, 0, 1,  1, 6'h00, 1,  6,  5);
    add(32'h100,     0, 6'h0, 0, 0,  0, 6'h00, 0,  6,  5);
    add(32'h104,     1, 6'h1, 1, 0,  0, 6'h01, 1,  7,  6);
    add(32'h104,     0, 6'h0, 0, 0,  1, 6'h01, 0,  7,  6);
    add(32'h107,     0, 6'h0, 0, 0,  1, 6'h01, 0,  7,  6);
    add(32'h204,     0, 6'h0, 0, 0,  1, 6'h01, 0,  7,  6);
    add(32'h108,     1, 6'h2, 0, 0,  0, 6'h02, 0,  8,  6);
    add(32'h108,     1, 6'h2, 0, 0,  0, 6'h02, 0,  9,  6);
    add(32'h108,     1, 6'h2, 1, 0,  0, 6'h02, 1, 10,  7);
    add(32'h108,     0, 6'h0, 0, 0,  0, 6'h02, 0, 10,  7);
    add(32'h10C,     0, 6'h0, 0, 0,  0, 6'h03, 0, 10,  7);
    add(32'h0FC,     1, 6'h3F,1, 0,  0, 6'h3F, 1, 11,  8);
    add(32'h0FC,     0, 6'h0, 0, 0,  1, 6'h3F, 0, 11,  8);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].pc, vecs[i].uv, vecs[i].uidx, vecs[i].ut, vecs[i].up);
      #1;
      chk($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_pred));
      chk($sformatf("v%0d pred_idx", i), 32'(pred_idx), 32'(vecs[i].e_idx));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(vecs[i].e_misp));
      chk($sformatf("v%0d stat_branches", i), stat_branches, vecs[i].e_br);
      chk($sformatf("v%0d stat_mispred", i), stat_mispred, vecs[i].e_mp);
    end

    // Reset coinciding with an update: the update is dropped and the table re-initialises.
    @(negedge clk);
    rst_n = 1'b0;
    drive(32'h100, 1'b1, 6'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("rst mispredict", 32'(mispredict), 32'd0);
    chk("rst stat_branches", stat_branches, 32'd0);
    chk("rst stat_mispred", stat_mispred, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h100, 1'b0, 6'h0, 1'b0, 1'b0);
    #1;
    chk("rst entry0 pred", 32'(pred_taken), 32'd0);
    lkp_pc = 32'h104;
    #1;
    chk("rst entry1 pred", 32'(pred_taken), 32'd0);
    lkp_pc = 32'h0FC;
    #1;
    chk("rst entry63 pred", 32'(pred_taken), 32'd0);
    // Entry 0 came back as 01: a single taken update must flip it.
    drive(32'h100, 1'b1, 6'h0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("rst entry0 after T", 32'(pred_taken), 32'd1);

    // Statistics wrap.
    @(negedge clk);
    force dut.r_stat_branches = 32'hFFFF_FFFF;
    #1;
    release dut.r_stat_branches;
    drive(32'h100, 1'b1, 6'h5, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("wrap stat_branches", stat_branches, 32'd0);
    chk("wrap stat_mispred", stat_mispred, 32'd1);
    chk("wrap mispredict", 32'(mispredict), 32'd1);
    @(negedge clk);
    drive(32'h100, 1'b0, 6'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("idle mispredict", 32'(mispredict), 32'd0);
    chk("idle stat_branches", stat_branches, 32'd0);
`else
    // Gshare: history shifts in each resolved outcome; lookup index is pc bits ^ GHR.
    @(negedge clk);
    drive(32'h100, 1'b0, 6'h0, 1'b0, 1'b0);
    #1;
    chk("gs reset pred_idx", 32'(pred_idx), 32'h00);
    chk("gs reset pred", 32'(pred_taken), 32'd0);
    drive(32'h100, 1'b1, 6'h10, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("gs T1 pred_idx", 32'(pred_idx), 32'h01);
    chk("gs T1 mispredict", 32'(mispredict), 32'd1);
    @(negedge clk);
    drive(32'h100, 1'b1, 6'h10, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("gs T2 pred_idx", 32'(pred_idx), 32'h03);
    @(negedge clk);
    drive(32'h100, 1'b1, 6'h10, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("gs TTN pred_idx", 32'(pred_idx), 32'h06);
    chk("gs stat_branches", stat_branches, 32'd3);
    chk("gs stat_mispred", stat_mispred, 32'd3);
    @(negedge clk);
    drive(32'h100, 1'b0, 6'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("gs hold pred_idx", 32'(pred_idx), 32'h06);
    chk("gs hold mispredict", 32'(mispredict), 32'd0);
    // Entry 0x10 went 01->10->11->10: visible via pc whose bits xor GHR to 0x10.
    lkp_pc = 32'h058;
    #1;
    chk("gs entry10 idx", 32'(pred_idx), 32'h10);
    chk("gs entry10 pred", 32'(pred_taken), 32'd1);
    do_reset();
    lkp_pc = 32'h100;
    #1;
    chk("gs rst pred_idx", 32'(pred_idx), 32'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
